// File: rtl/param_lock_controller_if.sv
// Keypad-side bundle for the lock controller: digit strobes and commands in, status out.
// No backpressure; every strobe is consumed or dropped in the cycle it is presented.
interface param_lock_controller_if #(
  parameter int DIGITS   = 6,
  parameter int DIGIT_W  = 4,
  parameter int MAX_FAIL = 3
);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);

  logic                        digit_valid;
  logic [DIGIT_W-1:0]          digit;
  logic                        cancel;
  logic                        relock;
  logic [DIGITS*DIGIT_W-1:0]   disp;
  logic [CNT_W-1:0]            digit_cnt;
  logic                        unlock;
  logic                        fail;
  logic                        lockout;
  logic                        code_set;
  logic [FCNT_W-1:0]           fail_cnt;

  modport master (
    output digit_valid, digit, cancel, relock,
    input  disp, digit_cnt, unlock, fail, lockout, code_set, fail_cnt
  );

  modport slave (
    input  digit_valid, digit, cancel, relock,
    output disp, digit_cnt, unlock, fail, lockout, code_set, fail_cnt
  );
endinterface

// File: rtl/param_lock_controller.sv
// N-digit lock: buffers digits, verifies in a one-cycle CHECK state, handles lockout, auto-relock and code change.
// Digit visible one edge after strobe, verdict one edge after the last digit; strobes in CHECK/LOCKOUT are dropped.
module param_lock_controller #(
  parameter int                            DIGITS       = 6,
  parameter int                            DIGIT_W      = 4,
  parameter int                            MAX_FAIL     = 3,
  parameter int                            LOCKOUT_CYC  = 1000,
  parameter int                            UNLOCK_CYC   = 5000,
  parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = '0
) (
  input  logic                   clk,
  input  logic                   clr,
  param_lock_controller_if.slave bus
);
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = (LOCKOUT_CYC < 2) ? 1 : $clog2(LOCKOUT_CYC);
  localparam int IDLE_W = (UNLOCK_CYC < 2) ? 1 : $clog2(UNLOCK_CYC);
  localparam int BUF_W  = DIGITS * DIGIT_W;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DIGITS);
  localparam logic [FCNT_W-1:0] FAIL_LAST = FCNT_W'(MAX_FAIL - 1);
  localparam logic [FCNT_W-1:0] FAIL_MAX  = FCNT_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (UNLOCK_CYC == 0) ? '0 : IDLE_W'(UNLOCK_CYC - 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_CHECK    = 2'd1,
    S_UNLOCKED = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [BUF_W-1:0]    r_buf;
  logic [BUF_W-1:0]    r_code;
  logic [CNT_W-1:0]    r_cnt;
  logic [FCNT_W-1:0]   r_fail_cnt;
  logic [LOCK_W-1:0]   r_lock_tmr;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_fail;
  logic                r_code_set;

  logic [BUF_W-1:0]    w_next_buf;
  logic                w_last;
  logic                w_activity;
  int                  w_slot;

  // First digit lands in the most-significant slot.
  always_comb begin
    w_next_buf = r_buf;
    w_slot     = DIGITS - 1 - int'(r_cnt);
    if (r_cnt < CNT_FULL) begin
      w_next_buf[w_slot*DIGIT_W +: DIGIT_W] = bus.digit;
    end
  end

  assign w_last     = (r_cnt == CNT_LAST);
  assign w_activity = bus.digit_valid | bus.cancel;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_LOCKED;
      r_buf      <= '0;
      r_code     <= DEFAULT_CODE;
      r_cnt      <= '0;
      r_fail_cnt <= '0;
      r_lock_tmr <= '0;
      r_idle     <= '0;
      r_fail     <= 1'b0;
      r_code_set <= 1'b0;
    end else begin
      r_fail     <= 1'b0;
      r_code_set <= 1'b0;
      case (r_state)
        S_LOCKED: begin
          if (bus.cancel) begin
            r_buf <= '0;
            r_cnt <= '0;
          end else if (bus.digit_valid) begin
            r_buf <= w_next_buf;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_buf <= '0;
          r_cnt <= '0;
          if (r_buf == r_code) begin
            r_state    <= S_UNLOCKED;
            r_fail_cnt <= '0;
            r_idle     <= '0;
          end else begin
            r_fail <= 1'b1;
            if (r_fail_cnt >= FAIL_LAST) begin
              r_fail_cnt <= FAIL_MAX;
              r_lock_tmr <= '0;
              r_state    <= S_LOCKOUT;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
              r_state    <= S_LOCKED;
            end
          end
        end
        S_UNLOCKED: begin
          if (w_activity) r_idle <= '0;
          else if (r_idle != IDLE_LAST) r_idle <= r_idle + 1'b1;
          // cancel outranks relock, which outranks a pending digit
          if (bus.cancel) begin
            r_buf <= '0;
            r_cnt <= '0;
          end else if (bus.relock) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_state <= S_LOCKED;
          end else if (bus.digit_valid) begin
            if (w_last) begin
              r_code     <= w_next_buf;
              r_code_set <= 1'b1;
              r_buf      <= '0;
              r_cnt      <= '0;
            end else begin
              r_buf <= w_next_buf;
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (UNLOCK_CYC != 0 && r_idle == IDLE_LAST) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKOUT: begin
          if (r_lock_tmr == LOCK_LAST) begin
            r_fail_cnt <= '0;
            r_state    <= S_LOCKED;
          end else begin
            r_lock_tmr <= r_lock_tmr + 1'b1;
          end
        end
        default: r_state <= S_LOCKED;
      endcase
    end
  end

  assign bus.disp      = r_buf;
  assign bus.digit_cnt = r_cnt;
  assign bus.unlock    = (r_state == S_UNLOCKED);
  assign bus.lockout   = (r_state == S_LOCKOUT);
  assign bus.fail      = r_fail;
  assign bus.code_set  = r_code_set;
  assign bus.fail_cnt  = r_fail_cnt;
endmodule

// File: tb/tb_param_lock_controller.sv
// Directed bench for param_lock_controller with hand-computed expectations.
module tb_param_lock_controller;
  localparam int DIGITS = 6, DIGIT_W = 4, MAX_FAIL = 3, LOCKOUT_CYC = 20, UNLOCK_CYC = 50;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  param_lock_controller_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL)) bus ();

  param_lock_controller #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(UNLOCK_CYC), .DEFAULT_CODE(24'h123456)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) send_digit(c[i*4 +: 4]);
  endtask

  task automatic do_relock();
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
  endtask

  task automatic test_reset();
    bus.digit_valid = 1'b0; bus.digit = '0; bus.cancel = 1'b0; bus.relock = 1'b0;
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    checks++;
    if ({bus.unlock, bus.fail, bus.lockout, bus.code_set} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.unlock, bus.fail, bus.lockout, bus.code_set});
    end
    checks++;
    if (bus.disp !== 24'h0 || bus.digit_cnt !== 3'd0 || bus.fail_cnt !== 2'd0) begin
      failures++; $display("FAIL reset_regs disp=%h cnt=%0d fcnt=%0d exp 0/0/0", bus.disp, bus.digit_cnt, bus.fail_cnt);
    end
  endtask

  task automatic test_unlock();
    send_digit(1); send_digit(2); send_digit(3);
    checks++;
    if (bus.disp !== 24'h123000 || bus.digit_cnt !== 3'd3) begin
      failures++; $display("FAIL partial_entry disp=%h cnt=%0d exp 123000/3", bus.disp, bus.digit_cnt);
    end
    send_digit(4); send_digit(5); send_digit(6);
    checks++;
    if (bus.disp !== 24'h123456 || bus.unlock !== 1'b0) begin
      failures++; $display("FAIL full_entry disp=%h unlock=%b exp 123456/0", bus.disp, bus.unlock);
    end
    tick();
    checks++;
    if (bus.unlock !== 1'b1 || bus.fail_cnt !== 2'd0 || bus.disp !== 24'h0 || bus.digit_cnt !== 3'd0) begin
      failures++; $display("FAIL unlock_verdict unlock=%b fcnt=%0d disp=%h cnt=%0d exp 1/0/0/0",
                           bus.unlock, bus.fail_cnt, bus.disp, bus.digit_cnt);
    end
    do_relock();
    checks++;
    if (bus.unlock !== 1'b0) begin
      failures++; $display("FAIL relock got=%b exp=0", bus.unlock);
    end
  endtask

  task automatic test_lockout();
    int n;
    bit bad_disp;
    for (int k = 1; k <= 3; k++) begin
      enter_code(24'h123457);
      tick();
      checks++;
      if (bus.fail !== 1'b1 || bus.fail_cnt !== 2'(k)) begin
        failures++; $display("FAIL wrong_entry_%0d fail=%b fcnt=%0d exp 1/%0d", k, bus.fail, bus.fail_cnt, k);
      end
      checks++;
      if (bus.lockout !== (k == 3)) begin
        failures++; $display("FAIL lockout_entry_%0d got=%b exp=%b", k, bus.lockout, (k == 3));
      end
      if (k < 3) begin
        tick();
        checks++;
        if (bus.fail !== 1'b0) begin
          failures++; $display("FAIL fail_pulse_width_%0d got=%b exp=0", k, bus.fail);
        end
      end
    end
    n = 1;
    bad_disp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.digit_valid = (i < 5);
      bus.digit       = 4'd9;
      tick();
      bus.digit_valid = 1'b0;
      if (bus.disp !== 24'h0) bad_disp = 1'b1;
      if (bus.lockout !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != LOCKOUT_CYC) begin
      failures++; $display("FAIL lockout_length got=%0d exp=%0d", n, LOCKOUT_CYC);
    end
    checks++;
    if (bad_disp) begin
      failures++; $display("FAIL lockout_digits_ignored got=disp_changed exp=disp_0");
    end
    checks++;
    if (bus.fail_cnt !== 2'd0 || bus.unlock !== 1'b0 || bus.digit_cnt !== 3'd0) begin
      failures++; $display("FAIL after_lockout fcnt=%0d unlock=%b cnt=%0d exp 0/0/0", bus.fail_cnt, bus.unlock, bus.digit_cnt);
    end
  endtask

  task automatic test_fail_then_ok();
    enter_code(24'h123457);
    tick();
    checks++;
    if (bus.fail_cnt !== 2'd1) begin
      failures++; $display("FAIL one_wrong fcnt=%0d exp=1", bus.fail_cnt);
    end
    enter_code(24'h123456);
    tick();
    checks++;
    if (bus.unlock !== 1'b1 || bus.fail_cnt !== 2'd0) begin
      failures++; $display("FAIL then_right unlock=%b fcnt=%0d exp 1/0", bus.unlock, bus.fail_cnt);
    end
    do_relock();
  endtask

  task automatic test_code_change();
    enter_code(24'h123456);
    tick();
    send_digit(9); send_digit(8); send_digit(7); send_digit(6); send_digit(5);
    checks++;
    if (bus.code_set !== 1'b0 || bus.disp !== 24'h98765_0) begin
      failures++; $display("FAIL new_code_partial code_set=%b disp=%h exp 0/987650", bus.code_set, bus.disp);
    end
    send_digit(4);
    checks++;
    if (bus.code_set !== 1'b1 || bus.unlock !== 1'b1 || bus.disp !== 24'h0 || bus.digit_cnt !== 3'd0) begin
      failures++; $display("FAIL code_set_pulse cs=%b unlock=%b disp=%h cnt=%0d exp 1/1/0/0",
                           bus.code_set, bus.unlock, bus.disp, bus.digit_cnt);
    end
    tick();
    checks++;
    if (bus.code_set !== 1'b0) begin
      failures++; $display("FAIL code_set_width got=%b exp=0", bus.code_set);
    end
    do_relock();
    enter_code(24'h123456);
    tick();
    checks++;
    if (bus.fail !== 1'b1 || bus.unlock !== 1'b0) begin
      failures++; $display("FAIL old_code_rejected fail=%b unlock=%b exp 1/0", bus.fail, bus.unlock);
    end
    enter_code(24'h987654);
    tick();
    checks++;
    if (bus.unlock !== 1'b1 || bus.fail_cnt !== 2'd0) begin
      failures++; $display("FAIL new_code_accepted unlock=%b fcnt=%0d exp 1/0", bus.unlock, bus.fail_cnt);
    end
    do_relock();
  endtask

  task automatic test_cancel();
    send_digit(1); send_digit(2); send_digit(3);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    checks++;
    if (bus.digit_cnt !== 3'd0 || bus.disp !== 24'h0) begin
      failures++; $display("FAIL cancel_partial cnt=%0d disp=%h exp 0/0", bus.digit_cnt, bus.disp);
    end
    tick();
    checks++;
    if (bus.fail !== 1'b0) begin
      failures++; $display("FAIL cancel_no_fail got=%b exp=0", bus.fail);
    end
    send_digit(1); send_digit(2); send_digit(3); send_digit(4); send_digit(5);
    bus.cancel      = 1'b1;
    bus.digit_valid = 1'b1;
    bus.digit       = 4'd7;
    tick();
    bus.cancel      = 1'b0;
    bus.digit_valid = 1'b0;
    checks++;
    if (bus.digit_cnt !== 3'd0 || bus.disp !== 24'h0) begin
      failures++; $display("FAIL cancel_last_digit cnt=%0d disp=%h exp 0/0", bus.digit_cnt, bus.disp);
    end
    tick();
    checks++;
    if (bus.fail !== 1'b0 || bus.unlock !== 1'b0 || bus.fail_cnt !== 2'd0) begin
      failures++; $display("FAIL cancel_no_check fail=%b unlock=%b fcnt=%0d exp 0/0/0", bus.fail, bus.unlock, bus.fail_cnt);
    end
  endtask

  task automatic test_auto_relock();
    int n;
    enter_code(24'h987654);
    tick();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (bus.unlock !== 1'b1) break;
    end
    checks++;
    if (n != UNLOCK_CYC) begin
      failures++; $display("FAIL auto_relock_idle got=%0d exp=%0d", n, UNLOCK_CYC);
    end
    enter_code(24'h987654);
    tick();
    repeat (30) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (bus.unlock !== 1'b1) break;
    end
    checks++;
    if (n != UNLOCK_CYC) begin
      failures++; $display("FAIL auto_relock_reload got=%0d exp=%0d", n, UNLOCK_CYC);
    end
  endtask

  task automatic test_clr_in_lockout();
    for (int k = 0; k < 3; k++) begin
      enter_code(24'h123457);
      tick();
    end
    checks++;
    if (bus.lockout !== 1'b1) begin
      failures++; $display("FAIL clr_setup_lockout got=%b exp=1", bus.lockout);
    end
    repeat (5) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.lockout !== 1'b0 || bus.unlock !== 1'b0 || bus.fail_cnt !== 2'd0) begin
      failures++; $display("FAIL clr_aborts_lockout lockout=%b unlock=%b fcnt=%0d exp 0/0/0",
                           bus.lockout, bus.unlock, bus.fail_cnt);
    end
    enter_code(24'h123456);
    tick();
    checks++;
    if (bus.unlock !== 1'b1) begin
      failures++; $display("FAIL clr_restores_code unlock=%b exp=1", bus.unlock);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_fail_then_ok();
    test_code_change();
    test_cancel();
    test_auto_relock();
    test_clr_in_lockout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
